// File: rtl/fp32_dot_accumulator.sv
// Multi-cycle FP32 accumulator: sums VEC_LEN products per result through ALIGN/ADD/NORM/ROUND.
// Rounding mode macro FP_ACC_ROUND_RNE_EN: defined = round-to-nearest-even, undefined = truncate.
module fp32_dot_accumulator #(
  parameter int VEC_LEN = 4,
  parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_sum,
  output logic        overflow,
  output logic        underflow
);
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} state_e;

  state_e            state_q, state_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       prod_q, prod_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_sum_q, out_sum_d;
  logic              overflow_q, overflow_d, underflow_q, underflow_d;

  // Inter-stage datapath registers
  logic              sign_q, sign_d;
  logic              sub_q, sub_d;
  logic signed [9:0] exp_q, exp_d;
  logic [26:0]       man_a_q, man_a_d, man_b_q, man_b_d;
  logic [27:0]       sum_q, sum_d;
  logic [26:0]       norm_q, norm_d;
  logic              zero_q, zero_d;
  logic              special_q, special_d;
  logic [31:0]       special_val_q, special_val_d;

  // ALIGN stage signals
  logic [7:0]  x_exp, y_exp, big_exp, small_exp, exp_diff;
  logic [22:0] x_frac, y_frac;
  logic        x_inf, x_nan, y_inf, y_nan, swap, big_sign, is_special;
  logic [26:0] big_man, small_man, small_aln;
  logic [4:0]  shamt;
  logic [53:0] shift_ext;
  logic [31:0] special_res;

  always_comb begin
    x_exp  = acc_q[30:23];
    y_exp  = prod_q[30:23];
    x_inf  = (x_exp == 8'hFF) && (acc_q[22:0] == 23'h0);
    x_nan  = (x_exp == 8'hFF) && (acc_q[22:0] != 23'h0);
    y_inf  = (y_exp == 8'hFF) && (prod_q[22:0] == 23'h0);
    y_nan  = (y_exp == 8'hFF) && (prod_q[22:0] != 23'h0);
    // Subnormals become signed zero: exponent 0 with the fraction cleared.
    x_frac = (x_exp == 8'h00) ? 23'h0 : acc_q[22:0];
    y_frac = (y_exp == 8'h00) ? 23'h0 : prod_q[22:0];
    swap      = {y_exp, y_frac} > {x_exp, x_frac};
    big_sign  = swap ? prod_q[31] : acc_q[31];
    big_exp   = swap ? y_exp : x_exp;
    small_exp = swap ? x_exp : y_exp;
    big_man   = swap ? {(y_exp != 8'h00), y_frac, 3'b000} : {(x_exp != 8'h00), x_frac, 3'b000};
    small_man = swap ? {(x_exp != 8'h00), x_frac, 3'b000} : {(y_exp != 8'h00), y_frac, 3'b000};
    exp_diff  = big_exp - small_exp;
    shamt     = (exp_diff >= 8'd27) ? 5'd27 : exp_diff[4:0];
    shift_ext = {small_man, 27'h0} >> shamt;
    small_aln = {shift_ext[53:28], shift_ext[27] | (|shift_ext[26:0])};
    is_special = (x_exp == 8'hFF) || (y_exp == 8'hFF);
    if (x_nan || y_nan || (x_inf && y_inf && (acc_q[31] != prod_q[31])))
      special_res = 32'h7FC00000;
    else if (x_inf)
      special_res = {acc_q[31], 8'hFF, 23'h0};
    else
      special_res = {prod_q[31], 8'hFF, 23'h0};
  end

  // NORM stage signals
  logic [4:0]        lead, shl;
  logic [26:0]       norm_man;
  logic signed [9:0] norm_exp;
  logic              norm_zero;

  always_comb begin
    lead = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (sum_q[i]) lead = 5'(i);
    end
    shl = 5'd26 - lead;
    if (sum_q[27]) begin
      norm_man = {sum_q[27:2], sum_q[1] | sum_q[0]};
      norm_exp = exp_q + 10'sd1;
    end else begin
      norm_man = sum_q[26:0] << shl;
      norm_exp = exp_q - $signed({5'b00000, shl});
    end
    norm_zero = (sum_q == 28'h0);
  end

  // ROUND stage signals
  logic              round_up, round_ovf, round_unf;
  logic [24:0]       man25;
  logic [22:0]       rfrac;
  logic signed [9:0] rexp;
  logic [31:0]       round_res;

  always_comb begin
`ifdef FP_ACC_ROUND_RNE_EN
    round_up = norm_q[2] && (norm_q[1] || norm_q[0] || norm_q[3]);
`else
    // Truncation: guard, round and sticky are dropped.
    round_up = 1'b0 && (|norm_q[2:0]);
`endif
    man25 = {1'b0, norm_q[26:3]} + {24'h0, round_up};
    rfrac = man25[24] ? man25[23:1] : man25[22:0];
    rexp  = man25[24] ? exp_q + 10'sd1 : exp_q;
    round_ovf = 1'b0;
    round_unf = 1'b0;
    if (special_q) begin
      round_res = special_val_q;
    end else if (zero_q) begin
      round_res = 32'h0;
    end else if (rexp >= 10'sd255) begin
      round_ovf = 1'b1;
`ifdef FP_ACC_ROUND_RNE_EN
      round_res = {sign_q, 8'hFF, 23'h0};
`else
      round_res = {sign_q, 31'h7F7FFFFF};
`endif
    end else if (rexp <= 10'sd0) begin
      round_unf = 1'b1;
      round_res = {sign_q, 31'h0};
    end else begin
      round_res = {sign_q, rexp[7:0], rfrac};
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d       = state_q;
    acc_d         = acc_q;
    prod_d        = prod_q;
    cnt_d         = cnt_q;
    ovf_d         = ovf_q;
    unf_d         = unf_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    out_sum_d     = out_sum_q;
    overflow_d    = overflow_q;
    underflow_d   = underflow_q;
    sign_d        = sign_q;
    sub_d         = sub_q;
    exp_d         = exp_q;
    man_a_d       = man_a_q;
    man_b_d       = man_b_q;
    sum_d         = sum_q;
    norm_d        = norm_q;
    zero_d        = zero_q;
    special_d     = special_q;
    special_val_d = special_val_q;
    unique case (state_q)
      S_IDLE: begin
        if (out_valid_q) begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end else if (in_ready_q && in_valid) begin
          prod_d     = in_data;
          in_ready_d = 1'b0;
          state_d    = S_ALIGN;
        end else begin
          in_ready_d = 1'b1;
        end
      end
      S_ALIGN: begin
        sign_d        = big_sign;
        sub_d         = acc_q[31] ^ prod_q[31];
        exp_d         = $signed({2'b00, big_exp});
        man_a_d       = big_man;
        man_b_d       = small_aln;
        special_d     = is_special;
        special_val_d = special_res;
        state_d       = S_ADD;
      end
      S_ADD: begin
        sum_d   = sub_q ? ({1'b0, man_a_q} - {1'b0, man_b_q})
                        : ({1'b0, man_a_q} + {1'b0, man_b_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        norm_d  = norm_man;
        exp_d   = norm_exp;
        zero_d  = norm_zero;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        state_d = S_IDLE;
        if (cnt_q + 1'b1 == CNT_W'(VEC_LEN)) begin
          out_valid_d = 1'b1;
          out_sum_d   = round_res;
          overflow_d  = ovf_q | round_ovf;
          underflow_d = unf_q | round_unf;
          acc_d       = 32'h0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          in_ready_d  = 1'b0;
        end else begin
          acc_d      = round_res;
          cnt_d      = cnt_q + 1'b1;
          ovf_d      = ovf_q | round_ovf;
          unf_d      = unf_q | round_unf;
          in_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      state_d     = S_IDLE;
      acc_d       = 32'h0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      unf_d       = 1'b0;
      out_valid_d = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      in_ready_d  = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      acc_q         <= 32'h0;
      prod_q        <= 32'h0;
      cnt_q         <= '0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      in_ready_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_sum_q     <= 32'h0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      sign_q        <= 1'b0;
      sub_q         <= 1'b0;
      exp_q         <= '0;
      man_a_q       <= '0;
      man_b_q       <= '0;
      sum_q         <= '0;
      norm_q        <= '0;
      zero_q        <= 1'b0;
      special_q     <= 1'b0;
      special_val_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      prod_q        <= prod_d;
      cnt_q         <= cnt_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      out_sum_q     <= out_sum_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      sign_q        <= sign_d;
      sub_q         <= sub_d;
      exp_q         <= exp_d;
      man_a_q       <= man_a_d;
      man_b_q       <= man_b_d;
      sum_q         <= sum_d;
      norm_q        <= norm_d;
      zero_q        <= zero_d;
      special_q     <= special_d;
      special_val_q <= special_val_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_fp32_dot_accumulator.sv
// Directed bench for fp32_dot_accumulator: sums, rounding, overflow/underflow, handshake, rst/clear.
module tb_fp32_dot_accumulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_sum;
  logic        overflow;
  logic        underflow;

  int n_tests = 0;
  int n_fail  = 0;
  time accept_t [4];

`ifdef FP_ACC_ROUND_RNE_EN
  localparam logic [31:0] EXP_ROUND = 32'h3F800001;
  localparam logic [31:0] EXP_OVF   = 32'h7F800000;
`else
  localparam logic [31:0] EXP_ROUND = 32'h3F800000;
  localparam logic [31:0] EXP_OVF   = 32'h7F7FFFFF;
`endif

  fp32_dot_accumulator #(.VEC_LEN(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (at negedges) for in_ready, offers d, returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] d, input int idx);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_timeout", 32'(in_ready), 32'h1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    accept_t[idx] = $time;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic feed(input logic [31:0] p0, p1, p2, p3);
    send(p0, 0);
    send(p1, 1);
    send(p2, 2);
    send(p3, 3);
  endtask

  // Counts negedges from the one after the last accept until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("out_timeout", 32'(out_valid), 32'h1);
  endtask

  task automatic take(input string tag, input logic [31:0] sum, input logic ovf, input logic unf);
    int lat;
    wait_out(lat);
    check({tag, "_sum"}, out_sum, sum);
    check({tag, "_ovf"}, 32'(overflow), 32'(ovf));
    check({tag, "_unf"}, 32'(underflow), 32'(unf));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_drop"}, 32'(out_valid), 32'h0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    logic [31:0] held;

    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_flags", {30'h0, overflow, underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rel_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);

    // 1+2+3+4 with out_ready already high: spacing, latency, one-cycle hold
    out_ready = 1'b1;
    feed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    for (int i = 1; i < 4; i++)
      check($sformatf("gap%0d", i), 32'(accept_t[i] - accept_t[i-1]), 32'd50);
    wait_out(lat);
    check("latency", 32'(lat), 32'd4);
    check("sum10", out_sum, 32'h41200000);
    check("sum10_flags", {30'h0, overflow, underflow}, 32'h0);
    @(negedge clk);
    check("sum10_one_cycle", 32'(out_valid), 32'h0);
    check("sum10_in_ready", 32'(in_ready), 32'h1);
    out_ready = 1'b0;

    // Rounding of a tie-plus-round bit
    feed(32'h3F800000, 32'h33C00000, 32'h0, 32'h0);
    take("round", EXP_ROUND, 1'b0, 1'b0);

    // Overflow
    feed(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0);
    take("ovf", EXP_OVF, 1'b1, 1'b0);

    // Underflow, then flags must be clear on the next vector
    feed(32'h00C00000, 32'h80800000, 32'h0, 32'h0);
    take("unf", 32'h0, 1'b0, 1'b1);
    feed(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    take("ones", 32'h40800000, 1'b0, 1'b0);

    // Backpressure: hold out_ready low for 10 cycles
    feed(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
    wait_out(lat);
    held = out_sum;
    check("bp_sum", held, 32'h41200000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), {out_sum[31:2], out_valid, in_ready}, {held[31:2], 2'b10});
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_drop", 32'(out_valid), 32'h0);
    check("bp_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);

    // Reset during NORM of the second product
    send(32'h40000000, 0);
    send(32'h40000000, 1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'h0);
    check("mid_rst_out_sum", out_sum, 32'h0);
    check("mid_rst_valid_flags", {29'h0, out_valid, overflow, underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_rel", 32'(in_ready), 32'h1);
    @(negedge clk);
    feed(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
    take("twos", 32'h41000000, 1'b0, 1'b0);

    // Clear aborts a vector in progress
    send(32'h40800000, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'h1);
    check("clr_out_valid", 32'(out_valid), 32'h0);
    feed(32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
    take("clr_ones", 32'h40800000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/fp32_dot_accumulator.md
# fp32_dot_accumulator

Sequential FP32 accumulator that sits directly downstream of the pipelined FP32 multiplier in the matrix-multiply datapath. It consumes a stream of FP32 products over a valid/ready handshake and sums `VEC_LEN` of them into one dot-product element. It then presents the sum, with sticky overflow and underflow flags, on an output valid/ready handshake to the result-writeback stage.

## Interface
- `VEC_LEN`, default 4: number of products summed per output; must be 2 or more.
- `CNT_W`, default `$clog2(VEC_LEN)+1`: width of the product counter.
- `clk` in, 1: the single clock; all logic is rising-edge.
- `rst` in, 1: asynchronous, active-high reset.
- `clear` in, 1: synchronous abort of the current vector; takes priority over every handshake.
- `in_valid` in, 1: `in_data` holds a product.
- `in_ready` out, 1: the block accepts the product this cycle.
- `in_data` in, 32: FP32 product.
- `out_valid` out, 1: `out_sum` and the flags are valid.
- `out_ready` in, 1: downstream takes the result.
- `out_sum` out, 32: accumulated FP32 sum.
- `overflow` out, 1: sticky for the current vector.
- `underflow` out, 1: sticky for the current vector.

## Operation
- A product is accepted when `in_valid` and `in_ready` are both high at a rising edge.
- The accumulator register `acc` starts each vector at +0 (0x00000000). Each accepted product `p` computes `acc = acc + p`.
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. Each state lasts exactly one cycle. `in_ready` is high only in IDLE with `out_valid`=0.
- ALIGN:
  - Flush subnormal operands to signed zero.
  - Swap so that operand A has the larger magnitude.
  - Right-shift the smaller mantissa (with hidden 1) by the exponent difference, keeping guard, round and sticky bits. A difference of 27 or more leaves only the sticky bit.
- ADD: 28-bit mantissa add or subtract according to the signs.
- NORM:
  - Priority-encode the leading one.
  - Shift left and decrement the exponent, or shift right by 1 on carry-out and increment it.
  - An exact zero result is +0.
- ROUND: round the mantissa (see Configuration); a mantissa carry-out renormalises.
- Result classes:
  - Exponent of 255 or more gives ±inf (0x7F800000 / 0xFF800000) and sets `overflow`.
  - Exponent of 0 or less with a nonzero mantissa gives signed zero and sets `underflow`.
- Specials:
  - Any NaN operand, or inf + (−inf), gives 0x7FC00000.
  - inf plus a finite value gives that inf. This does not set `overflow`.
- Vector completion:
  - An internal counter counts completed additions.
  - On leaving ROUND with the count equal to `VEC_LEN`: set `out_valid`=1 with `out_sum`=`acc` and the flags, then reset `acc` to +0, the counter to 0 and the internal sticky flags.
  - `out_sum`, `overflow` and `underflow` stay stable while `out_valid`=1.
  - `out_valid` drops on the edge where `out_ready`=1. `in_ready` returns high the next cycle.
- `clear`: FSM to IDLE; `acc`, counter and flags zeroed; `out_valid`=0. Any pending result is discarded.
- Reset values: `in_ready`=0 while `rst` is high and 1 in the first cycle after release. `out_valid`=0, `out_sum`=0x00000000, `overflow`=0, `underflow`=0.
- `rst` asserted mid-addition or mid-handshake returns the block to reset state immediately; the partial vector is lost.

## Timing
- Product accepted at edge E0. States: ALIGN after E0, ADD after E1, NORM after E2, ROUND after E3. `acc` is updated at E4.
- `in_ready` is high again in the cycle after E4, so throughput is one product per 5 cycles.
- Last product of a vector accepted at E0 gives `out_valid`=1 after E4: 4 cycles from acceptance.
- If `out_ready` is already high when `out_valid` rises, the result is held for exactly one cycle.
- `in_data` is sampled only at the accepting edge. Changes while `in_ready`=0 are ignored.

## Configuration
- `FP_ACC_ROUND_RNE_EN` defined: round-to-nearest, ties-to-even, using guard, round and sticky.
- Not defined: round toward zero (truncate); guard, round and sticky are discarded. Overflow then saturates to ±0x7F7FFFFF instead of ±inf, and `overflow` is still set.

## Test plan
- `VEC_LEN`=4, products 0x3F800000, 0x40000000, 0x40400000, 0x40800000 (1, 2, 3, 4) → `out_sum`=0x41200000, both flags 0, each product accepted 5 cycles apart.
- 0x3F800000 + 0x33C00000, then two zeros → 0x3F800001 with the macro defined, 0x3F800000 without it.
- 0x7F7FFFFF + 0x7F7FFFFF, then two zeros → 0x7F800000 (RNE) or 0x7F7FFFFF (RTZ), `overflow`=1.
- 0x00C00000 + 0x80800000, then two zeros → 0x00000000, `underflow`=1. Next vector 1, 1, 1, 1 → 0x40800000 with both flags 0.
- Hold `out_ready`=0 for 10 cycles after `out_valid` rises → `out_sum` stable, `in_ready`=0 throughout. Release → `out_valid` falls on that edge.
- `rst` pulse during NORM of the second product → all outputs at reset values. A following vector 2, 2, 2, 2 → 0x41000000.
